// File: rtl/dcache_port_arbiter.sv
// +----------------------------------------------------------------------------+
// | dcache_port_arbiter: shares one D$ request port among NR_PORTS requesters   |
// | and routes in-order responses back. DCACHE_ARB_FIXED_PRIO_EN: fixed prio.   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module dcache_port_arbiter #(
  parameter int unsigned NR_PORTS        = 2,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned ADDR_W          = 64
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NR_PORTS-1:0]              req_i,
  input  logic [NR_PORTS-1:0][ADDR_W-1:0]  addr_i,
  input  logic [NR_PORTS-1:0]              we_i,
  input  logic [NR_PORTS-1:0][63:0]        wdata_i,
  input  logic [NR_PORTS-1:0][7:0]         be_i,
  output logic [NR_PORTS-1:0]              gnt_o,
  output logic [NR_PORTS-1:0]              rvalid_o,
  output logic [63:0]                      rdata_o,
  output logic                             dc_req_o,
  output logic [ADDR_W-1:0]                dc_addr_o,
  output logic                             dc_we_o,
  output logic [63:0]                      dc_wdata_o,
  output logic [7:0]                       dc_be_o,
  input  logic                             dc_gnt_i,
  input  logic                             dc_rvalid_i,
  input  logic [63:0]                      dc_rdata_i,
  output logic                             stray_rsp_o
);

  localparam int unsigned ID_W  = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;
  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [ID_W-1:0]  fifo_q [MAX_OUTSTANDING];
  logic [ID_W-1:0]  fifo_d [MAX_OUTSTANDING];
  logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lock_q, lock_d;
  logic [ID_W-1:0]  lock_sel_q, lock_sel_d;
`ifndef DCACHE_ARB_FIXED_PRIO_EN
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
`endif

  logic [ID_W-1:0]  arb_sel;
  logic [ID_W-1:0]  sel_w;
  logic             full_w, empty_w, dc_req_w, hs_w, pop_w;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  // First pass yields the lowest requester; the round-robin pass then
  // overrides it with the lowest requester at or above the pointer.
  always_comb begin
    arb_sel = '0;
    for (int i = int'(NR_PORTS) - 1; i >= 0; i--) begin
      if (req_i[i]) arb_sel = ID_W'(i);
    end
`ifndef DCACHE_ARB_FIXED_PRIO_EN
    for (int i = int'(NR_PORTS) - 1; i >= 0; i--) begin
      if (req_i[i] && (ID_W'(i) >= rr_ptr_q)) arb_sel = ID_W'(i);
    end
`endif
  end

  assign sel_w    = lock_q ? lock_sel_q : arb_sel;
  assign full_w   = (cnt_q == CNT_W'(MAX_OUTSTANDING));
  assign empty_w  = (cnt_q == '0);
  assign dc_req_w = rst_ni && !full_w && req_i[sel_w];
  assign hs_w     = dc_req_w && dc_gnt_i;
  assign pop_w    = rst_ni && dc_rvalid_i && !empty_w;

  assign dc_req_o    = dc_req_w;
  assign dc_addr_o   = rst_ni ? addr_i[sel_w]  : '0;
  assign dc_we_o     = rst_ni ? we_i[sel_w]    : 1'b0;
  assign dc_wdata_o  = rst_ni ? wdata_i[sel_w] : '0;
  assign dc_be_o     = rst_ni ? be_i[sel_w]    : '0;
  assign rdata_o     = rst_ni ? dc_rdata_i     : '0;
  assign stray_rsp_o = rst_ni && dc_rvalid_i && empty_w;

  always_comb begin
    gnt_o           = '0;
    gnt_o[sel_w]    = hs_w;
    rvalid_o        = '0;
    rvalid_o[fifo_q[rptr_q]] = pop_w;
  end

  always_comb begin
    fifo_d     = fifo_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    cnt_d      = cnt_q;
    lock_d     = lock_q;
    lock_sel_d = lock_sel_q;
`ifndef DCACHE_ARB_FIXED_PRIO_EN
    rr_ptr_d   = rr_ptr_q;
`endif
    if (hs_w) begin
      fifo_d[wptr_q] = sel_w;
      wptr_d         = ptr_inc(wptr_q);
      lock_d         = 1'b0;
`ifndef DCACHE_ARB_FIXED_PRIO_EN
      rr_ptr_d       = (sel_w == ID_W'(NR_PORTS - 1)) ? '0 : sel_w + 1'b1;
`endif
    end else if (dc_req_w) begin
      lock_d     = 1'b1;
      lock_sel_d = sel_w;
    end
    if (pop_w) rptr_d = ptr_inc(rptr_q);
    if (hs_w && !pop_w)      cnt_d = cnt_q + 1'b1;
    else if (!hs_w && pop_w) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      lock_q     <= 1'b0;
      lock_sel_q <= '0;
`ifndef DCACHE_ARB_FIXED_PRIO_EN
      rr_ptr_q   <= '0;
`endif
      for (int i = 0; i < int'(MAX_OUTSTANDING); i++) fifo_q[i] <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
      lock_q     <= lock_d;
      lock_sel_q <= lock_sel_d;
`ifndef DCACHE_ARB_FIXED_PRIO_EN
      rr_ptr_q   <= rr_ptr_d;
`endif
      fifo_q     <= fifo_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dcache_port_arbiter.sv
// +----------------------------------------------------------------------------+
// | tb_dcache_port_arbiter: directed and random checks against a queue model.   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_dcache_port_arbiter;

  localparam int NP   = 2;
  localparam int MAXO = 4;
  localparam int AW   = 64;

  logic                  clk_i = 1'b0;
  logic                  rst_ni;
  logic [NP-1:0]         req_i;
  logic [NP-1:0][AW-1:0] addr_i;
  logic [NP-1:0]         we_i;
  logic [NP-1:0][63:0]   wdata_i;
  logic [NP-1:0][7:0]    be_i;
  logic [NP-1:0]         gnt_o;
  logic [NP-1:0]         rvalid_o;
  logic [63:0]           rdata_o;
  logic                  dc_req_o;
  logic [AW-1:0]         dc_addr_o;
  logic                  dc_we_o;
  logic [63:0]           dc_wdata_o;
  logic [7:0]            dc_be_o;
  logic                  dc_gnt_i;
  logic                  dc_rvalid_i;
  logic [63:0]           dc_rdata_i;
  logic                  stray_rsp_o;

  dcache_port_arbiter #(.NR_PORTS(NP), .MAX_OUTSTANDING(MAXO), .ADDR_W(AW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .addr_i(addr_i), .we_i(we_i),
    .wdata_i(wdata_i), .be_i(be_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .dc_req_o(dc_req_o), .dc_addr_o(dc_addr_o), .dc_we_o(dc_we_o), .dc_wdata_o(dc_wdata_o),
    .dc_be_o(dc_be_o), .dc_gnt_i(dc_gnt_i), .dc_rvalid_i(dc_rvalid_i), .dc_rdata_i(dc_rdata_i),
    .stray_rsp_o(stray_rsp_o)
  );

  always #5 clk_i = ~clk_i;

  int tests = 0;
  int fails = 0;

  // Reference: queue of port ids awaiting a response, plus arbitration state.
  int      m_q[$];
  int      m_rr   = 0;
  bit      m_lock = 1'b0;
  int      m_lsel = 0;

  logic [NP-1:0] last_gnt, last_rv;
  logic          last_req, last_stray;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [NP-1:0] req);
    if (m_lock) return m_lsel;
`ifdef DCACHE_ARB_FIXED_PRIO_EN
    for (int p = 0; p < NP; p++) if (req[p]) return p;
`else
    for (int k = 0; k < NP; k++) if (req[(m_rr + k) % NP]) return (m_rr + k) % NP;
`endif
    return 0;
  endfunction

  task automatic step(input logic [NP-1:0] req, input logic gnt, input logic rv,
                      input logic [63:0] rd);
    int            sel;
    bit            exp_req, do_pop;
    logic [NP-1:0] exp_gnt, exp_rv;
    if (m_lock) req[m_lsel] = 1'b1;
    req_i = req; dc_gnt_i = gnt; dc_rvalid_i = rv; dc_rdata_i = rd;
    for (int p = 0; p < NP; p++) begin
      addr_i[p]  = {$urandom, $urandom};
      wdata_i[p] = {$urandom, $urandom};
      be_i[p]    = 8'($urandom);
      we_i[p]    = 1'($urandom);
    end
    #1;
    sel     = pick(req);
    exp_req = (m_q.size() < MAXO) && req[sel];
    exp_gnt = '0;
    if (exp_req && gnt) exp_gnt[sel] = 1'b1;
    do_pop  = rv && (m_q.size() > 0);
    exp_rv  = '0;
    if (do_pop) exp_rv[m_q[0]] = 1'b1;
    check("dc_req", 64'(dc_req_o), 64'(exp_req));
    check("gnt", 64'(gnt_o), 64'(exp_gnt));
    check("rvalid", 64'(rvalid_o), 64'(exp_rv));
    check("stray", 64'(stray_rsp_o), 64'(rv && !do_pop));
    check("rdata", rdata_o, rd);
    if (exp_req) begin
      check("dc_addr", dc_addr_o, addr_i[sel]);
      check("dc_wdata", dc_wdata_o, wdata_i[sel]);
      check("dc_be_we", {55'd0, dc_we_o, dc_be_o}, {55'd0, we_i[sel], be_i[sel]});
    end
    last_gnt = gnt_o; last_rv = rvalid_o; last_req = dc_req_o; last_stray = stray_rsp_o;
    @(posedge clk_i);
    if (do_pop) void'(m_q.pop_front());
    if (exp_req && gnt) begin
      m_q.push_back(sel);
      m_lock = 1'b0;
      m_rr   = (sel + 1) % NP;
    end else if (exp_req) begin
      m_lock = 1'b1;
      m_lsel = sel;
    end
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    req_i = '1; dc_gnt_i = 1'b1; dc_rvalid_i = 1'b1; dc_rdata_i = 64'hDEAD_BEEF;
    #1;
    check("rst_outs", {58'd0, gnt_o, rvalid_o, dc_req_o, stray_rsp_o}, 64'd0);
    check("rst_addr", dc_addr_o, 64'd0);
    check("rst_rdata", rdata_o, 64'd0);
    m_q.delete(); m_rr = 0; m_lock = 1'b0; m_lsel = 0;
    @(negedge clk_i);
    @(negedge clk_i);
    req_i = '0; dc_gnt_i = 1'b0; dc_rvalid_i = 1'b0;
    rst_ni = 1'b1;
  endtask

  initial begin
    req_i = '0; addr_i = '0; we_i = '0; wdata_i = '0; be_i = '0;
    dc_gnt_i = 1'b0; dc_rvalid_i = 1'b0; dc_rdata_i = '0;
    rst_ni = 1'b1;
    @(negedge clk_i);
    do_reset();

    // Stray response with nothing in flight, one-cycle pulse
    step(2'b00, 1'b0, 1'b1, 64'h55);
    check("stray_pulse", 64'({last_stray, last_rv}), 64'b100);
    step(2'b00, 1'b0, 1'b0, 64'h0);
    check("stray_clear", 64'(last_stray), 64'd0);

    // Both ports requesting continuously, responses lag by two cycles
    for (int c = 0; c < 8; c++) begin
      step(2'b11, 1'b1, (c >= 2), 64'(c));
`ifdef DCACHE_ARB_FIXED_PRIO_EN
      check("alt_gnt", 64'(last_gnt), 64'b01);
`else
      check("alt_gnt", 64'(last_gnt), (c % 2 == 0) ? 64'b01 : 64'b10);
`endif
    end
    step(2'b00, 1'b0, 1'b1, 64'h1);
    step(2'b00, 1'b0, 1'b1, 64'h2);

    // Stalled port 1 keeps the port even after port 0 starts requesting
    for (int c = 0; c < 5; c++) begin
      step((c < 2) ? 2'b10 : ((c < 4) ? 2'b11 : 2'b01), (c >= 3), 1'b0, 64'h0);
      if (c == 3)     check("lock_gnt1", 64'(last_gnt), 64'b10);
      else if (c < 3) check("lock_hold", 64'({last_req, last_gnt}), 64'b100);
      else            check("lock_next0", 64'(last_gnt), 64'b01);
    end
    step(2'b00, 1'b0, 1'b1, 64'h3);
    step(2'b00, 1'b0, 1'b1, 64'h4);

    // Fill the routing FIFO, then one response reopens it a cycle later
    for (int c = 0; c < 4; c++) step(2'b01, 1'b1, 1'b0, 64'h0);
    step(2'b01, 1'b1, 1'b0, 64'h0);
    check("full_noreq", 64'(last_req), 64'd0);
    step(2'b01, 1'b1, 1'b1, 64'h7);
    check("full_pop_noreq", 64'({last_req, last_rv}), 64'b001);
    step(2'b01, 1'b1, 1'b0, 64'h0);
    check("reopen_req", 64'(last_req), 64'd1);
    for (int c = 0; c < 4; c++) step(2'b00, 1'b0, 1'b1, 64'h0);

    // In-order response routing
    step(2'b10, 1'b1, 1'b0, 64'h0);
    step(2'b01, 1'b1, 1'b0, 64'h0);
    step(2'b10, 1'b1, 1'b0, 64'h0);
    step(2'b00, 1'b0, 1'b1, 64'hA);
    check("route_A", 64'(last_rv), 64'b10);
    step(2'b00, 1'b0, 1'b1, 64'hB);
    check("route_B", 64'(last_rv), 64'b01);
    step(2'b00, 1'b0, 1'b1, 64'hC);
    check("route_C", 64'(last_rv), 64'b10);

    // Reset with two in flight turns later responses into strays
    step(2'b01, 1'b1, 1'b0, 64'h0);
    step(2'b01, 1'b1, 1'b0, 64'h0);
    do_reset();
    step(2'b00, 1'b0, 1'b1, 64'h11);
    check("post_rst_stray0", 64'({last_stray, last_rv}), 64'b100);
    step(2'b00, 1'b0, 1'b1, 64'h22);
    check("post_rst_stray1", 64'({last_stray, last_rv}), 64'b100);

    for (int n = 0; n < 400; n++)
      step(NP'($urandom), ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 4),
           {$urandom, $urandom});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dcache_port_arbiter.md
DCACHE_PORT_ARBITER -- requirements
Module: dcache_port_arbiter

Interface
REQ-001 Parameter NR_PORTS, default 2: number of requesters sharing one D$ request port, range 2..4.
REQ-002 Parameter MAX_OUTSTANDING, default 4: depth of the in-flight response-routing FIFO, power of two.
REQ-003 Parameter ADDR_W, default 64: request address width.
REQ-004 One clock; reset is asynchronous and active-low.
REQ-005 clk_i  in  1  clock.
REQ-006 rst_ni  in  1  asynchronous active-low reset.
REQ-007 req_i  in  NR_PORTS  per-port request valid.
REQ-008 addr_i  in  NR_PORTS x ADDR_W  per-port address.
REQ-009 we_i  in  NR_PORTS  per-port write enable.
REQ-010 wdata_i  in  NR_PORTS x 64  per-port write data.
REQ-011 be_i  in  NR_PORTS x 8  per-port byte enable.
REQ-012 gnt_o  out  NR_PORTS  per-port grant.
REQ-013 rvalid_o  out  NR_PORTS  per-port response valid.
REQ-014 rdata_o  out  64  response data, broadcast to all ports.
REQ-015 dc_req_o, dc_addr_o, dc_we_o, dc_wdata_o, dc_be_o  out  1/ADDR_W/1/64/8  muxed D$ request.
REQ-016 dc_gnt_i, dc_rvalid_i  in  1  D$ grant and response valid; dc_rdata_i  in  64  D$ response data.
REQ-017 stray_rsp_o  out  1  one-cycle pulse on dc_rvalid_i with no request in flight.

Function
REQ-018 Selection, req-to-dc_req path and gnt path SHALL be combinational (zero-cycle latency).
REQ-019 While unlocked and FIFO not full, the arbiter SHALL select the first requesting port at or after rr_ptr_q (round-robin) and drive its payload onto dc_*_o with dc_req_o=1.
REQ-020 gnt_o[k] SHALL equal dc_gnt_i AND dc_req_o AND (selected==k); at most one gnt_o bit is set per cycle.
REQ-021 If dc_req_o=1 and dc_gnt_i=0, lock_q SHALL be set and the same port kept selected until its handshake, regardless of other requests; a selected port dropping req_i while locked is a protocol violation (not handled).
REQ-022 On handshake of port k: push k into the ID FIFO, clear lock_q, set rr_ptr_q=(k+1) mod NR_PORTS.
REQ-023 With FIFO full (count==MAX_OUTSTANDING), dc_req_o SHALL be 0, including when a pop occurs that same cycle.
REQ-024 Responses return in order: on dc_rvalid_i with FIFO non-empty, rvalid_o[head]=1 in the same cycle, rdata_o=dc_rdata_i, head popped.
REQ-025 dc_rvalid_i with FIFO empty SHALL drop the response, keep rvalid_o=0 and pulse stray_rsp_o.
REQ-026 Simultaneous push and pop SHALL leave the count unchanged; read/write pointers wrap modulo MAX_OUTSTANDING.
REQ-027 Writes also occupy a FIFO entry; the D$ returns one rvalid per granted request.

Reset
REQ-028 On rst_ni low: FIFO empty, pointers 0, rr_ptr_q=0, lock_q=0; all outputs 0 while in reset.
REQ-029 Reset mid-transaction SHALL discard all in-flight routing state; later rvalids count as stray.

Configuration
REQ-030 With DCACHE_ARB_FIXED_PRIO_EN defined, selection SHALL be fixed priority (lowest index wins, rr_ptr_q unused); without it, round-robin per REQ-019/022. Locking and FIFO behaviour are identical in both builds.

Verification
REQ-031 req_i=2'b11 continuously, dc_gnt_i=1, rvalid 2 cycles later -> grants alternate 0,1,0,1 (round-robin); with macro, port 0 always.
REQ-032 Port 1 requests, dc_gnt_i=0 for 3 cycles, port 0 requests in cycle 2 -> dc_addr_o stays addr_i[1] until grant; port 0 granted next.
REQ-033 4 grants with no rvalid -> count=4, dc_req_o=0; one rvalid -> dc_req_o=1 the following cycle.
REQ-034 Grants to ports 1,0,1, then three rvalids with rdata 0xA,0xB,0xC -> rvalid_o[1]=0xA, rvalid_o[0]=0xB, rvalid_o[1]=0xC.
REQ-035 dc_rvalid_i=1 after reset with nothing granted -> stray_rsp_o=1 for one cycle, rvalid_o=0.
REQ-036 rst_ni low with 2 in flight, then 2 rvalids -> two stray_rsp_o pulses, no rvalid_o.
